// File: rtl/acc_seq_wb.sv
// acc_seq_wb: sequencer and writeback controller for the window accumulator.
// Counts ACC_LEN accepted partial sums per output window, clears the
// accumulator on each window's first beat, then writes the finished sum to
// the output buffer at an incrementing address.
// Optional build macro: ACC_SEQ_RELU_EN -- clamp negative window sums to zero
// on writeback.
module acc_seq_wb #(
    parameter int ACC_LEN = 25,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_out,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              acc_clear,
    output logic              acc_enable,
    input  logic [DATA_W-1:0] acc_sum,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WRITE,
        FIN
    } state_t;

    localparam logic [7:0] BEAT_LAST = 8'(ACC_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        beat_cnt;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W-1:0] job_len;
    logic              last_beat;
    logic              last_out;
    logic [DATA_W-1:0] wb_data;

    assign in_ready   = (state == ACCUM);
    assign busy       = (state != IDLE);
    assign acc_enable = in_valid && in_ready;
    assign acc_clear  = acc_enable && (beat_cnt == '0);
    assign last_beat  = (beat_cnt == BEAT_LAST);
    assign last_out   = (out_addr == (job_len - ADDR_W'(1)));

`ifdef ACC_SEQ_RELU_EN
    assign wb_data = acc_sum[DATA_W-1] ? '0 : acc_sum;
`else
    assign wb_data = acc_sum;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: job start, window completion, job completion.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_out == '0) ? FIN : ACCUM;
                end
            end
            ACCUM: begin
                if (acc_enable && last_beat) begin
                    state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = last_out ? FIN : ACCUM;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job bookkeeping, beat counting and registered writeback/done strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            out_addr <= '0;
            job_len  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            done     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        job_len  <= num_out;
                        out_addr <= '0;
                        beat_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (acc_enable) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + 8'd1;
                    end
                end
                WRITE: begin
                    wr_en    <= 1'b1;
                    wr_data  <= wb_data;
                    wr_addr  <= out_addr;
                    out_addr <= out_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_wb.sv
// Self-checking bench for acc_seq_wb. A simple registered accumulator stands
// in for the real one; expected timing and window sums come from a
// beat-counting reference model.
module tb_acc_seq_wb;

    localparam int ACC_LEN = 25;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_out = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              acc_clear;
    logic              acc_enable;
    logic [DATA_W-1:0] acc_sum;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] sum_in = '0;
    logic [DATA_W-1:0] acc_reg = '0;

    int n_assert = 0;
    int n_fail   = 0;

    acc_seq_wb #(
        .ACC_LEN(ACC_LEN),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_out   (num_out),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_clear (acc_clear),
        .acc_enable(acc_enable),
        .acc_sum   (acc_sum),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Accumulator stand-in: clear loads the incoming sum, enable adds it.
    assign acc_sum = acc_reg;
    always @(posedge clk) begin
        if (acc_enable) acc_reg <= acc_clear ? sum_in : acc_reg + sum_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] wb_expect(input logic [DATA_W-1:0] s);
`ifdef ACC_SEQ_RELU_EN
        return s[DATA_W-1] ? '0 : s;
`else
        return s;
`endif
    endfunction

    task automatic check_reset_outputs(input string ctx);
        chk({ctx, "_wr_en"}, wr_en, 0);
        chk({ctx, "_wr_addr"}, wr_addr, 0);
        chk({ctx, "_wr_data"}, wr_data, 0);
        chk({ctx, "_done"}, done, 0);
        chk({ctx, "_busy"}, busy, 0);
        chk({ctx, "_in_ready"}, in_ready, 0);
        chk({ctx, "_acc_enable"}, acc_enable, 0);
        chk({ctx, "_acc_clear"}, acc_clear, 0);
    endtask

    // One job. vmode: 0 always valid, 1 alternate, 2 random.
    // dmode: 0 ones, 1 window index, 2 random, 3 first beat -5 then zeros.
    // dup_start: cycle on which a stray start pulse is sent (-1 none).
    // abort_beats: return after this many beats of the second window (-1 none).
    task automatic run_job(input int num, input int vmode, input int dmode,
                           input int dup_start, input int abort_beats);
        int wins = 0, beats = 0, last_beat = -100, exp_wr_cyc = -100;
        int wr_seen = 0, done_seen = 0, done_cyc = -1, last_wr = -100;
        int budget;
        logic [DATA_W-1:0] wsum = '0, v, exp_data = '0;
        logic [ADDR_W-1:0] exp_addr = '0;
        logic vld, exp_ready, acc;
        budget = 20 + (num + 1) * ACC_LEN * 6;
        @(negedge clk);
        start = 1'b1; num_out = ADDR_W'(num); in_valid = 1'b0; sum_in = '0;
        #1;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_acc_enable", acc_enable, 0);
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start   = (c == dup_start);
            num_out = (c == dup_start) ? ADDR_W'(num + 7) : ADDR_W'(num);
            case (vmode)
                0:       vld = 1'b1;
                1:       vld = c[0];
                default: vld = ($urandom_range(0, 3) != 0);
            endcase
            case (dmode)
                0:       v = 16'd1;
                1:       v = 16'(wins);
                2:       v = 16'($urandom);
                default: v = (beats == 0) ? 16'hFFFB : 16'h0000;
            endcase
            in_valid = vld; sum_in = v;
            #1;
            exp_ready = (wins < num) && (c != last_beat + 1);
            acc = vld && exp_ready;
            chk("in_ready", in_ready, exp_ready);
            chk("acc_enable", acc_enable, acc);
            chk("acc_clear", acc_clear, acc && (beats == 0));
            if (exp_ready) chk("busy_accum", busy, 1);
            chk("wr_en", wr_en, c == exp_wr_cyc);
            if (wr_en && c == exp_wr_cyc) begin
                chk("wr_addr", wr_addr, exp_addr);
                chk("wr_data", wr_data, exp_data);
                wr_seen++;
                last_wr = c;
            end
            if (done) begin
                done_seen++;
                done_cyc = c;
            end
            if (acc) begin
                wsum = (beats == 0) ? v : wsum + v;
                beats++;
                if (beats == ACC_LEN) begin
                    beats      = 0;
                    exp_wr_cyc = c + 2;
                    exp_addr   = ADDR_W'(wins);
                    exp_data   = wb_expect(wsum);
                    wins++;
                    last_beat  = c;
                end
            end
            if (abort_beats >= 0 && wins == 1 && beats == abort_beats) begin
                start = 1'b0;
                return;
            end
            if (done_seen > 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; in_valid = 1'b0;
        chk("write_count", wr_seen, num);
        chk("done_count", done_seen, 1);
        if (num == 0) chk("done_latency_empty", done_cyc, 2);
        else chk("done_after_last_write", (done_cyc - last_wr == 1) || (done_cyc - last_wr == 2), 1);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("post_release");

        run_job(1, 0, 0, -1, -1);   // basic window, sum 25
        run_job(1, 1, 0, -1, -1);   // stalled stream, sum 25
        run_job(3, 0, 1, 5, -1);    // multi-output 0/25/50, stray start ignored
        run_job(1, 0, 3, -1, -1);   // window sum -5 through writeback
        run_job(4, 2, 2, -1, -1);   // random data and gaps
        run_job(0, 0, 0, -1, -1);   // empty job

        // Reset partway through the second window of a three-output job.
        run_job(3, 0, 1, -1, 10);
        @(negedge clk);
        in_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_rst");
        @(negedge clk);
        #1;
        check_reset_outputs("midjob_rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            #1;
            chk("post_rst_no_write", wr_en, 0);
            chk("post_rst_idle", busy, 0);
        end
        in_valid = 1'b0;
        run_job(1, 0, 2, -1, -1);   // fresh job after abort

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
